// File: rtl/matrix_alu_pkg.sv
// Shared definitions for the sequential matrix ALU: opcodes, FSM states and
// default register-file write addresses.
package matrix_alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam int         WIDTH_DEFAULT  = 512;
    localparam logic [1:0] DST_LO_DEFAULT = 2'd2;
    localparam logic [1:0] DST_HI_DEFAULT = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        ARITH,
        ITER,
        FIX,
        WRITE
    } state_t;

    // Opcodes with the upper bit set go through the bit-serial datapath.
    function automatic logic is_iterative(input logic [1:0] opc);
        return opc[1];
    endfunction

endpackage

// File: rtl/shift_muldiv_core.sv
// Unsigned bit-serial datapath: LSB-first shift-add multiply or restoring
// divide, one bit per step. Results are magnitudes; signs are handled outside.
module shift_muldiv_core #(
    parameter int WIDTH = 512
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             mode_div,
    input  logic [WIDTH-1:0] mag_a,
    input  logic [WIDTH-1:0] mag_b,
    output logic             last_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             div_q, div_d;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   part_rem;
    logic             fits;

    assign sum_ext  = {1'b0, acc_q} + {1'b0, opnd_q};
    // Partial remainder with the next dividend bit shifted in.
    assign part_rem = {acc_q, shift_q[WIDTH-1]};
    assign fits     = (part_rem >= {1'b0, opnd_q});

    always_comb begin
        acc_d   = acc_q;
        shift_d = shift_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        if (load) begin
            acc_d   = '0;
            shift_d = mag_a;
            opnd_d  = mag_b;
            cnt_d   = '0;
            div_d   = mode_div;
        end else if (step) begin
            cnt_d = cnt_q + 1'b1;
            if (div_q) begin
                if (fits) begin
                    acc_d   = WIDTH'(part_rem - {1'b0, opnd_q});
                    shift_d = {shift_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d   = part_rem[WIDTH-1:0];
                    shift_d = {shift_q[WIDTH-2:0], 1'b0};
                end
            end else if (shift_q[0]) begin
                {acc_d, shift_d} = {sum_ext, shift_q[WIDTH-1:1]};
            end else begin
                {acc_d, shift_d} = {1'b0, acc_q, shift_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q   <= '0;
            shift_q <= '0;
            opnd_q  <= '0;
            cnt_q   <= '0;
            div_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            shift_q <= shift_d;
            opnd_q  <= opnd_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
        end
    end

    assign last_o = (cnt_q == CW'(WIDTH - 1));
    assign lo_o   = shift_q;
    assign hi_o   = acc_q;

endmodule

// File: rtl/matrix_seq_alu.sv
// Sequential signed add/sub/mul/div unit between register-file entries 0/1
// and the write ports for entries 2/3 (low half / high half of the result).
module matrix_seq_alu
    import matrix_alu_pkg::*;
#(
    parameter int         WIDTH  = WIDTH_DEFAULT,
    parameter logic [1:0] DST_LO = DST_LO_DEFAULT,
    parameter logic [1:0] DST_HI = DST_HI_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       opcode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] wr_data1,
    output logic [1:0]       wr_addr1,
    output logic             wr_en1,
    output logic [WIDTH-1:0] wr_data2,
    output logic [1:0]       wr_addr2,
    output logic             wr_en2
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             alt_q, alt_d;       // sub (vs add) or div (vs mul)
    logic             iter_load_q, iter_load_d;
    logic [WIDTH-1:0] data1_q, data1_d;
    logic [WIDTH-1:0] data2_q, data2_d;
    logic             dbz_q, dbz_d;

    logic             core_load, core_step, core_last;
    logic [WIDTH-1:0] core_lo, core_hi;

    logic [WIDTH:0]     a_ext, b_ext, arith_res;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               neg_res;
    logic [2*WIDTH-1:0] prod_mag, prod_signed;

    assign a_ext       = {a_q[WIDTH-1], a_q};
    assign b_ext       = {b_q[WIDTH-1], b_q};
    assign arith_res   = alt_q ? (a_ext - b_ext) : (a_ext + b_ext);
    assign mag_a       = a_q[WIDTH-1] ? (~a_q + 1'b1) : a_q;
    assign mag_b       = b_q[WIDTH-1] ? (~b_q + 1'b1) : b_q;
    assign neg_res     = a_q[WIDTH-1] ^ b_q[WIDTH-1];
    assign prod_mag    = {core_hi, core_lo};
    assign prod_signed = neg_res ? (~prod_mag + 1'b1) : prod_mag;

    shift_muldiv_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk     (clk),
        .reset   (reset),
        .load    (core_load),
        .step    (core_step),
        .mode_div(alt_q),
        .mag_a   (mag_a),
        .mag_b   (mag_b),
        .last_o  (core_last),
        .lo_o    (core_lo),
        .hi_o    (core_hi)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        alt_d       = alt_q;
        iter_load_d = iter_load_q;
        data1_d     = data1_q;
        data2_d     = data2_q;
        dbz_d       = dbz_q;
        core_load   = 1'b0;
        core_step   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d         = op_a;
                    b_d         = op_b;
                    alt_d       = opcode[0];
                    dbz_d       = 1'b0;
                    iter_load_d = 1'b1;
                    state_d     = is_iterative(opcode) ? ITER : ARITH;
                end
            end
            ARITH: begin
                data1_d = arith_res[WIDTH-1:0];
                data2_d = {WIDTH{arith_res[WIDTH]}};
                state_d = WRITE;
            end
            ITER: begin
                // First ITER cycle loads magnitudes of the captured operands;
                // WIDTH step cycles follow.
                if (iter_load_q) begin
                    core_load   = 1'b1;
                    iter_load_d = 1'b0;
                end else begin
                    core_step = 1'b1;
                    if (core_last) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                if (!alt_q) begin
                    {data2_d, data1_d} = prod_signed;
                end else if (b_q == '0) begin
                    data1_d = '0;
                    data2_d = a_q;
                    dbz_d   = 1'b1;
                end else begin
                    // Quotient truncates toward zero; remainder follows dividend.
                    data1_d = neg_res ? (~core_lo + 1'b1) : core_lo;
                    data2_d = a_q[WIDTH-1] ? (~core_hi + 1'b1) : core_hi;
                end
                state_d = WRITE;
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            alt_q       <= 1'b0;
            iter_load_q <= 1'b0;
            data1_q     <= '0;
            data2_q     <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            alt_q       <= alt_d;
            iter_load_q <= iter_load_d;
            data1_q     <= data1_d;
            data2_q     <= data2_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == WRITE);
    assign wr_en1      = done;
    assign wr_en2      = done;
    assign wr_data1    = data1_q;
    assign wr_data2    = data2_q;
    assign wr_addr1    = DST_LO;
    assign wr_addr2    = DST_HI;
    assign div_by_zero = dbz_q;

endmodule
